// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline: control-bundle layout, access-size
// codes and helpers that build or gate the ID/EX control word.
package mips_pipe_pkg;

  localparam int EX_D_W  = 7;
  localparam int MEM_D_W = 2;
  localparam int WB_D_W  = 2;

  localparam int REGDST   = 6;
  localparam int ALUSRC   = 5;
  localparam int MEMWRITE = 1;
  localparam int MEMREAD  = 0;
  localparam int REGWRITE = 1;
  localparam int MEMTOREG = 0;

  localparam int RA_IDX = 31;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  // Everything that must be zero in a bubble so the slot can never write.
  typedef struct packed {
    logic               valid;
    logic [EX_D_W-1:0]  ex_d;
    logic [MEM_D_W-1:0] mem_d;
    logic [WB_D_W-1:0]  wb_d;
    logic [1:0]         size;
    logic               syscall;
    logic               jal;
  } ctrl_t;

  function automatic ctrl_t bubble_ctrl();
    return '0;
  endfunction

  function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic v);
    return v ? c : bubble_ctrl();
  endfunction

endpackage

// File: rtl/id_ex_hazard.sv
// Load-use hazard detection and the combined fetch/decode stall request.
module id_ex_hazard #(
  parameter int REG_W = 5
) (
  input  logic             reset,
  input  logic             id_valid,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_hold,
  output logic             lu_haz,
  output logic             stall_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs && (ex_rt == id_rs);
  assign rt_hit = id_uses_rt && (ex_rt == id_rt);

  // A load into $zero has no real destination, so it never blocks decode.
  assign lu_haz = id_valid && ex_valid && ex_mem_read && (ex_rt != '0)
                  && (rs_hit || rt_hit);

  assign stall_o = !reset && (lu_haz || ex_hold);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decode controls and operands for EX,
// inserts bubbles on load-use hazards and flushes, and freezes under ex_hold.
module id_ex_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [EX_D_W-1:0]   id_ex_d,
  input  logic [MEM_D_W-1:0]  id_mem_d,
  input  logic [WB_D_W-1:0]   id_wb_d,
  input  logic [1:0]          id_size,
  input  logic                id_syscall,
  input  logic                id_jal,
  input  logic [DATA_W-1:0]   id_rs_val,
  input  logic [DATA_W-1:0]   id_rt_val,
  input  logic [DATA_W-1:0]   id_imm,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic [REG_W-1:0]    id_rd,
  input  logic [4:0]          id_shamt,
  input  logic [DATA_W-1:0]   id_pc4,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                ex_hold,
  input  logic                flush,
  output logic                stall_o,
  output logic                ex_valid,
  output logic [EX_D_W-1:0]   ex_ex_d,
  output logic [MEM_D_W-1:0]  ex_mem_d,
  output logic [WB_D_W-1:0]   ex_wb_d,
  output logic [1:0]          ex_size,
  output logic                ex_syscall,
  output logic                ex_jal,
  output logic [DATA_W-1:0]   ex_rs_val,
  output logic [DATA_W-1:0]   ex_rt_val,
  output logic [DATA_W-1:0]   ex_imm,
  output logic [REG_W-1:0]    ex_rs,
  output logic [REG_W-1:0]    ex_rt,
  output logic [4:0]          ex_shamt,
  output logic [DATA_W-1:0]   ex_pc4,
  output logic [REG_W-1:0]    ex_dst,
  output logic [CNT_W-1:0]    bubble_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] pc4;
    logic [REG_W-1:0]  dst;
  } data_t;

  ctrl_t            ctrl_q, ctrl_d, id_ctrl;
  data_t            data_q, data_d, id_data;
  logic             flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             lu_haz;

  id_ex_hazard #(.REG_W(REG_W)) u_hazard (
    .reset       (reset),
    .id_valid    (id_valid),
    .ex_valid    (ctrl_q.valid),
    .ex_mem_read (ctrl_q.mem_d[MEMREAD]),
    .ex_rt       (data_q.rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_hold     (ex_hold),
    .lu_haz      (lu_haz),
    .stall_o     (stall_o)
  );

  always_comb begin
    id_ctrl = '{valid: id_valid, ex_d: id_ex_d, mem_d: id_mem_d, wb_d: id_wb_d,
                size: id_size, syscall: id_syscall, jal: id_jal};
    id_data.rs_val = id_rs_val;
    id_data.rt_val = id_rt_val;
    id_data.imm    = id_imm;
    id_data.rs     = id_rs;
    id_data.rt     = id_rt;
    id_data.shamt  = id_shamt;
    id_data.pc4    = id_pc4;
    id_data.dst    = id_jal ? REG_W'(RA_IDX) : (id_ex_d[REGDST] ? id_rd : id_rt);
  end

  // NOTE: every next-state variable is defaulted to its current value first,
  // so no path through the if/else can leave one unassigned and infer a latch.
  always_comb begin
    ctrl_d       = ctrl_q;
    data_d       = data_q;
    flush_pend_d = flush_pend_q;
    bubble_cnt_d = bubble_cnt_q;
    if (ex_hold) begin
      if (flush) flush_pend_d = 1'b1;
    end else begin
      data_d       = id_data;
      flush_pend_d = 1'b0;
      // A flush and a hazard in the same cycle still cost a single bubble.
      if (flush || flush_pend_q || lu_haz) begin
        ctrl_d       = bubble_ctrl();
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end else begin
        ctrl_d = gate_ctrl(id_ctrl, id_valid);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q       <= '0;
      data_q       <= '0;
      flush_pend_q <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      data_q       <= data_d;
      flush_pend_q <= flush_pend_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid   = ctrl_q.valid;
  assign ex_ex_d    = ctrl_q.ex_d;
  assign ex_mem_d   = ctrl_q.mem_d;
  assign ex_wb_d    = ctrl_q.wb_d;
  assign ex_size    = ctrl_q.size;
  assign ex_syscall = ctrl_q.syscall;
  assign ex_jal     = ctrl_q.jal;
  assign ex_rs_val  = data_q.rs_val;
  assign ex_rt_val  = data_q.rt_val;
  assign ex_imm     = data_q.imm;
  assign ex_rs      = data_q.rs;
  assign ex_rt      = data_q.rt;
  assign ex_shamt   = data_q.shamt;
  assign ex_pc4     = data_q.pc4;
  assign ex_dst     = data_q.dst;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: table of instruction slots with expected EX
// contents, then hand sequences for hold/flush, async reset and counter wrap.
module tb_id_ex_stage;
  import mips_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 0;
  logic [6:0]  id_ex_d = '0;
  logic [1:0]  id_mem_d = '0, id_wb_d = '0, id_size = '0;
  logic        id_syscall = 0, id_jal = 0;
  logic [31:0] id_rs_val = '0, id_rt_val = '0, id_imm = '0, id_pc4 = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0, id_shamt = '0;
  logic        id_uses_rs = 0, id_uses_rt = 0, ex_hold = 0, flush = 0;

  logic        stall_o, ex_valid, ex_syscall, ex_jal;
  logic [6:0]  ex_ex_d;
  logic [1:0]  ex_mem_d, ex_wb_d, ex_size;
  logic [31:0] ex_rs_val, ex_rt_val, ex_imm, ex_pc4, bubble_cnt;
  logic [4:0]  ex_rs, ex_rt, ex_shamt, ex_dst;

  logic        w_stall, w_valid, w_syscall, w_jal;
  logic [6:0]  w_ex_d;
  logic [1:0]  w_mem_d, w_wb_d, w_size;
  logic [31:0] w_rs_val, w_rt_val, w_imm, w_pc4;
  logic [4:0]  w_rs, w_rt, w_shamt, w_dst;
  logic [1:0]  w_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ex_d(id_ex_d),
    .id_mem_d(id_mem_d), .id_wb_d(id_wb_d), .id_size(id_size),
    .id_syscall(id_syscall), .id_jal(id_jal), .id_rs_val(id_rs_val),
    .id_rt_val(id_rt_val), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_shamt(id_shamt), .id_pc4(id_pc4),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_hold(ex_hold),
    .flush(flush), .stall_o(stall_o), .ex_valid(ex_valid), .ex_ex_d(ex_ex_d),
    .ex_mem_d(ex_mem_d), .ex_wb_d(ex_wb_d), .ex_size(ex_size),
    .ex_syscall(ex_syscall), .ex_jal(ex_jal), .ex_rs_val(ex_rs_val),
    .ex_rt_val(ex_rt_val), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_shamt(ex_shamt), .ex_pc4(ex_pc4), .ex_dst(ex_dst),
    .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter copy used only to observe wrap-around.
  id_ex_stage #(.CNT_W(2)) dut_wrap (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ex_d(id_ex_d),
    .id_mem_d(id_mem_d), .id_wb_d(id_wb_d), .id_size(id_size),
    .id_syscall(id_syscall), .id_jal(id_jal), .id_rs_val(id_rs_val),
    .id_rt_val(id_rt_val), .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_shamt(id_shamt), .id_pc4(id_pc4),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_hold(ex_hold),
    .flush(flush), .stall_o(w_stall), .ex_valid(w_valid), .ex_ex_d(w_ex_d),
    .ex_mem_d(w_mem_d), .ex_wb_d(w_wb_d), .ex_size(w_size),
    .ex_syscall(w_syscall), .ex_jal(w_jal), .ex_rs_val(w_rs_val),
    .ex_rt_val(w_rt_val), .ex_imm(w_imm), .ex_rs(w_rs), .ex_rt(w_rt),
    .ex_shamt(w_shamt), .ex_pc4(w_pc4), .ex_dst(w_dst),
    .bubble_cnt(w_cnt)
  );

  typedef struct {
    logic       v;
    logic [6:0] exd;
    logic [1:0] memd, wbd;
    logic       jal;
    logic [4:0] rs, rt, rd;
    logic       urs, urt, fl;
    logic       e_stall, e_valid;
    logic [6:0] e_exd;
    logic [1:0] e_memd, e_wbd;
    logic       e_jal, chk_data;
    logic [4:0] e_dst;
    int         e_cnt;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [6:0] exd, input logic [1:0] memd,
                           input logic [1:0] wbd, input logic jal, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic urs,
                           input logic urt, input int tag);
    id_valid = v; id_ex_d = exd; id_mem_d = memd; id_wb_d = wbd; id_jal = jal;
    id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rs = urs; id_uses_rt = urt;
    id_syscall = 1'b0; id_size = SIZE_WORD;
    id_rs_val = 32'hA000_0000 + 32'(tag);
    id_rt_val = 32'hB000_0000 + 32'(tag);
    id_imm    = 32'(tag) * 4;
    id_pc4    = 32'h0040_0000 + 32'(tag) * 4;
    id_shamt  = 5'(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".stall"}, 64'(stall_o), 64'd0);
    check({tag, ".ex_valid"}, 64'(ex_valid), 64'd0);
    check({tag, ".ctrl"}, 64'({ex_ex_d, ex_mem_d, ex_wb_d, ex_size, ex_syscall, ex_jal}), 64'd0);
    check({tag, ".data"}, 64'({ex_rs_val, ex_pc4} ^ {ex_rt_val, ex_imm}), 64'd0);
    check({tag, ".rs_val"}, 64'(ex_rs_val), 64'd0);
    check({tag, ".regs"}, 64'({ex_rs, ex_rt, ex_shamt, ex_dst}), 64'd0);
    check({tag, ".cnt"}, 64'(bubble_cnt), 64'd0);
  endtask

  initial begin
    //            v  exd    md    wd    j  rs  rt  rd u  u  f | st vl exd   md    wd    j  cd dst cnt
    vecs[0]  = '{1, 7'h20, 2'b01, 2'b11, 0, 9, 8, 0, 1, 0, 0,  0, 1, 7'h20, 2'b01, 2'b11, 0, 1, 8, 0};
    vecs[1]  = '{1, 7'h41, 2'b00, 2'b10, 0, 8, 11, 10, 1, 1, 0, 1, 0, 7'h00, 2'b00, 2'b00, 0, 0, 0, 1};
    vecs[2]  = '{1, 7'h41, 2'b00, 2'b10, 0, 8, 11, 10, 1, 1, 0, 0, 1, 7'h41, 2'b00, 2'b10, 0, 1, 10, 1};
    vecs[3]  = '{1, 7'h20, 2'b01, 2'b11, 0, 10, 0, 0, 1, 0, 0, 0, 1, 7'h20, 2'b01, 2'b11, 0, 1, 0, 1};
    vecs[4]  = '{1, 7'h41, 2'b00, 2'b10, 0, 0, 0, 12, 1, 1, 0, 0, 1, 7'h41, 2'b00, 2'b10, 0, 1, 12, 1};
    vecs[5]  = '{1, 7'h20, 2'b01, 2'b11, 0, 2, 13, 0, 1, 0, 0, 0, 1, 7'h20, 2'b01, 2'b11, 0, 1, 13, 1};
    vecs[6]  = '{1, 7'h20, 2'b01, 2'b11, 0, 13, 14, 0, 1, 0, 0, 1, 0, 7'h00, 2'b00, 2'b00, 0, 0, 0, 2};
    vecs[7]  = '{1, 7'h20, 2'b01, 2'b11, 0, 13, 14, 0, 1, 0, 0, 0, 1, 7'h20, 2'b01, 2'b11, 0, 1, 14, 2};
    vecs[8]  = '{1, 7'h41, 2'b00, 2'b10, 0, 3, 14, 15, 0, 1, 0, 1, 0, 7'h00, 2'b00, 2'b00, 0, 0, 0, 3};
    vecs[9]  = '{1, 7'h41, 2'b00, 2'b10, 0, 3, 14, 15, 0, 1, 0, 0, 1, 7'h41, 2'b00, 2'b10, 0, 1, 15, 3};
    vecs[10] = '{1, 7'h00, 2'b00, 2'b10, 1, 0, 0, 5, 0, 0, 0, 0, 1, 7'h00, 2'b00, 2'b10, 1, 1, 31, 3};
    vecs[11] = '{1, 7'h21, 2'b00, 2'b10, 0, 3, 7, 9, 1, 0, 0, 0, 1, 7'h21, 2'b00, 2'b10, 0, 1, 7, 3};
    vecs[12] = '{0, 7'h41, 2'b10, 2'b10, 0, 1, 2, 4, 1, 1, 0, 0, 0, 7'h00, 2'b00, 2'b00, 0, 1, 4, 3};
    vecs[13] = '{1, 7'h41, 2'b00, 2'b10, 0, 1, 2, 6, 1, 1, 1, 0, 0, 7'h00, 2'b00, 2'b00, 0, 0, 0, 4};
    vecs[14] = '{1, 7'h20, 2'b01, 2'b11, 0, 9, 8, 0, 1, 0, 0, 0, 1, 7'h20, 2'b01, 2'b11, 0, 1, 8, 4};
    vecs[15] = '{1, 7'h41, 2'b00, 2'b10, 0, 8, 8, 10, 1, 1, 1, 1, 0, 7'h00, 2'b00, 2'b00, 0, 0, 0, 5};
    vecs[16] = '{1, 7'h41, 2'b00, 2'b10, 0, 8, 8, 10, 1, 1, 0, 0, 1, 7'h41, 2'b00, 2'b10, 0, 1, 10, 5};
    vecs[17] = '{1, 7'h20, 2'b01, 2'b11, 0, 4, 20, 0, 1, 0, 0, 0, 1, 7'h20, 2'b01, 2'b11, 0, 1, 20, 5};
    vecs[18] = '{1, 7'h21, 2'b00, 2'b10, 0, 20, 21, 0, 0, 1, 0, 0, 1, 7'h21, 2'b00, 2'b10, 0, 1, 21, 5};
    vecs[19] = '{1, 7'h20, 2'b01, 2'b11, 0, 4, 22, 0, 1, 0, 0, 0, 1, 7'h20, 2'b01, 2'b11, 0, 1, 22, 5};
    vecs[20] = '{0, 7'h41, 2'b00, 2'b10, 0, 22, 22, 3, 1, 1, 0, 0, 0, 7'h00, 2'b00, 2'b00, 0, 1, 3, 5};

    // Reset state, including stall_o gated while reset is high.
    ex_hold = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset0");
    @(negedge clk);
    ex_hold = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      set_instr(vecs[i].v, vecs[i].exd, vecs[i].memd, vecs[i].wbd, vecs[i].jal,
                vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].urs, vecs[i].urt, i + 1);
      flush = vecs[i].fl;
      #1;
      check($sformatf("v%0d.stall", i), 64'(stall_o), 64'(vecs[i].e_stall));
      step();
      check($sformatf("v%0d.ex_valid", i), 64'(ex_valid), 64'(vecs[i].e_valid));
      check($sformatf("v%0d.ex_ex_d", i), 64'(ex_ex_d), 64'(vecs[i].e_exd));
      check($sformatf("v%0d.ex_mem_d", i), 64'(ex_mem_d), 64'(vecs[i].e_memd));
      check($sformatf("v%0d.ex_wb_d", i), 64'(ex_wb_d), 64'(vecs[i].e_wbd));
      check($sformatf("v%0d.ex_jal", i), 64'(ex_jal), 64'(vecs[i].e_jal));
      check($sformatf("v%0d.bubble_cnt", i), 64'(bubble_cnt), 64'(vecs[i].e_cnt));
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d.ex_dst", i), 64'(ex_dst), 64'(vecs[i].e_dst));
        check($sformatf("v%0d.ex_rs_val", i), 64'(ex_rs_val), 64'h0000_0000_A000_0000 + 64'(i + 1));
        check($sformatf("v%0d.ex_pc4", i), 64'(ex_pc4), 64'h0040_0000 + 64'((i + 1) * 4));
      end
    end
    flush = 1'b0;

    // Hold for 3 cycles with a flush in the middle cycle: EX frozen, then one bubble.
    set_instr(1, 7'h20, 2'b10, 2'b00, 0, 5, 6, 0, 1, 1, 100);
    step();
    check("hold.load_valid", 64'(ex_valid), 64'd1);
    for (int c = 0; c < 3; c++) begin
      set_instr(1, 7'h41, 2'b00, 2'b10, 0, 1, 2, 3, 1, 1, 200 + c);
      ex_hold = 1'b1;
      flush = (c == 1);
      #1;
      check($sformatf("hold%0d.stall", c), 64'(stall_o), 64'd1);
      step();
      check($sformatf("hold%0d.ex_valid", c), 64'(ex_valid), 64'd1);
      check($sformatf("hold%0d.ctrl", c), 64'({ex_ex_d, ex_mem_d, ex_wb_d}), 64'({7'h20, 2'b10, 2'b00}));
      check($sformatf("hold%0d.rs_val", c), 64'(ex_rs_val), 64'hA000_0000 + 64'd100);
      check($sformatf("hold%0d.dst", c), 64'(ex_dst), 64'd6);
      check($sformatf("hold%0d.cnt", c), 64'(bubble_cnt), 64'd5);
    end
    ex_hold = 1'b0;
    flush = 1'b0;
    set_instr(1, 7'h41, 2'b00, 2'b10, 0, 1, 2, 10, 1, 1, 300);
    #1;
    check("unhold.stall", 64'(stall_o), 64'd0);
    step();
    check("unhold.bubble_valid", 64'(ex_valid), 64'd0);
    check("unhold.cnt", 64'(bubble_cnt), 64'd6);
    step();
    check("unhold.pend_cleared", 64'(ex_valid), 64'd1);
    check("unhold.ex_d", 64'(ex_ex_d), 64'h41);
    check("unhold.cnt2", 64'(bubble_cnt), 64'd6);

    // Asynchronous reset mid-cycle with a load in EX.
    set_instr(1, 7'h20, 2'b01, 2'b11, 0, 9, 8, 0, 1, 0, 400);
    step();
    check("prereset.mem_d", 64'(ex_mem_d), 64'b01);
    #3;
    reset = 1'b1;
    ex_hold = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    reset = 1'b0;
    ex_hold = 1'b0;

    // Reset while a flush is pending: nothing is replayed afterwards.
    set_instr(1, 7'h41, 2'b00, 2'b10, 0, 1, 2, 10, 1, 1, 500);
    step();
    ex_hold = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("pend_rst.cnt", 64'(bubble_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    ex_hold = 1'b0;
    set_instr(1, 7'h21, 2'b00, 2'b10, 0, 3, 7, 0, 1, 0, 600);
    step();
    check("pend_rst.no_replay", 64'(ex_valid), 64'd1);
    check("pend_rst.dst", 64'(ex_dst), 64'd7);
    check("pend_rst.cnt_after", 64'(bubble_cnt), 64'd0);

    // Counter wrap on the 2-bit copy: three flushes reach all-ones, the fourth wraps.
    flush = 1'b1;
    repeat (3) step();
    check("wrap.all_ones", 64'(w_cnt), 64'd3);
    check("wrap.wide_cnt3", 64'(bubble_cnt), 64'd3);
    step();
    check("wrap.zero", 64'(w_cnt), 64'd0);
    check("wrap.wide_cnt4", 64'(bubble_cnt), 64'd4);
    flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core.
- Captures the decode-stage control bundles (EX_D, MEM_D, WB_D, byte size, syscall/jal flags) together with operands and register indices, and presents them to the EX stage one cycle later.
- Owns load-use hazard detection: it stalls fetch/decode and inserts a bubble.
- Honours an EX-side hold and a branch/jump flush, including a flush that arrives while the hold is active.

Parameters:
- DATA_W, 32, operand/PC width
- REG_W, 5, register index width
- CNT_W, 32, bubble counter width

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  decode slot holds a real instruction
- id_ex_d  in  7  {RegDst, ALUsrc, ALUop[4:0]}
- id_mem_d  in  2  {MemWrite, MemRead}
- id_wb_d  in  2  {RegWrite, MemToReg}
- id_size  in  2  access size code (SIZE_BYTE/HALF/WORD)
- id_syscall  in  1  syscall decoded
- id_jal  in  1  jal decoded
- id_rs_val  in  DATA_W  register-file read A
- id_rt_val  in  DATA_W  register-file read B
- id_imm  in  DATA_W  sign-extended immediate
- id_rs  in  REG_W  rs index
- id_rt  in  REG_W  rt index
- id_rd  in  REG_W  rd index
- id_shamt  in  5  shift amount
- id_pc4  in  DATA_W  PC+4 of the decode instruction
- id_uses_rs  in  1  decode instruction reads rs
- id_uses_rt  in  1  decode instruction reads rt
- ex_hold  in  1  EX busy (e.g. DIV); freeze this register
- flush  in  1  squash the decode-slot instruction (taken branch/jump)
- stall_o  out  1  hold PC and IF/ID (combinational)
- ex_valid, ex_ex_d, ex_mem_d, ex_wb_d, ex_size, ex_syscall, ex_jal, ex_rs_val, ex_rt_val, ex_imm, ex_rs, ex_rt, ex_shamt, ex_pc4  out  registered copies of the corresponding id_* inputs
- ex_dst  out  REG_W  registered destination: 31 if jal, else rd if RegDst, else rt
- bubble_cnt  out  CNT_W  count of bubbles inserted by load-use or flush

Behaviour:
- Reset (asynchronous, active-high): all outputs go to 0, including ex_valid, every control bundle, bubble_cnt and flush_pend. stall_o is 0 while reset is asserted.
- Hazard (combinational), lu_haz = id_valid & ex_valid & ex_mem_d[0] & (ex_rt != 0) & ((id_uses_rs & ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- stall_o = lu_haz | ex_hold.
- State: one bit, flush_pend, records a flush that arrived during ex_hold.
- Per-edge priority:
  1. reset.
  2. ex_hold=1: all ex_* outputs hold their values. If flush=1, flush_pend<=1. No counter change.
  3. flush | flush_pend: bubble. ex_valid, control bundles, syscall and jal go to 0; data fields are don't-care and are loaded anyway. flush_pend<=0. bubble_cnt+1.
  4. lu_haz: bubble as in (3). bubble_cnt+1. Decode holds via stall_o, so the instruction is re-presented next cycle, when the hazard has cleared.
  5. Otherwise: load all id_* fields. ex_valid<=id_valid. Control bundles are ANDed with id_valid, so an invalid slot never writes.
- Latency: exactly 1 cycle, ID to EX, when not stalled.
- A load-use hazard costs exactly 1 bubble. Back-to-back dependent loads each cost 1 bubble.
- A flush and a hazard in the same cycle: counts as 1 bubble, not 2.
- bubble_cnt wraps modulo 2^CNT_W with no saturation.
- ex_rt == 0 never produces a hazard ($zero).
- Reset asserted mid-hold or mid-flush_pend clears everything; there is no replay.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - bundle widths (EX_D_W=7, MEM_D_W=2, WB_D_W=2);
  - bit positions (REGDST=6, ALUSRC=5, MEMWRITE=1, MEMREAD=0, REGWRITE=1, MEMTOREG=0);
  - the SIZE_* codes and the RA index 31;
  - a function that forms the bubble (all-zero control).
- One sub-module, id_ex_hazard: the combinational lu_haz / stall_o logic, reused later by the forwarding unit.

Test Plan:
- lw $8,0($9), then add $10,$8,$11 → stall_o=1 for 1 cycle; ex_valid=0 on the bubble cycle; add reaches EX next cycle; bubble_cnt=1.
- lw $0,.. followed by add using $0 → no stall, no bubble, bubble_cnt=0.
- ex_hold=1 for 3 cycles with flush pulsed in cycle 2:
  - ex_* frozen for 3 cycles;
  - the first edge after the hold has ex_valid=0 and bubble_cnt+1;
  - flush_pend is cleared.
- jal with rd=5, RegDst=0 → ex_dst=31, ex_jal=1, ex_wb_d[1]=1. Then addi rt=7 → ex_dst=7.
- Assert reset asynchronously mid-cycle while ex_valid=1 and ex_mem_d=2'b01 → all outputs 0 before the next edge; stall_o=0.
- Force bubble_cnt to all-ones, then one flush → bubble_cnt=0.
